// File: rtl/ex_mem_stage.sv
// Execute stage with the EX/MEM pipeline register: forwarding, ALU, branch resolution,
// and the registered redirect that also flushes IF/ID and ID/EX.
module ex_mem_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemRead,
  input  logic            MemtoReg,
  input  logic            MemWrite,
  input  logic            ALUSrc,
  input  logic            RegWrite,
  input  logic            branch,
  input  logic [XLEN-1:0] ReadData1,
  input  logic [XLEN-1:0] ReadData2,
  input  logic [XLEN-1:0] imm_data,
  input  logic [XLEN-1:0] address,
  input  logic [3:0]      funct,
  input  logic [4:0]      rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [1:0]      AluOp,
  input  logic            wb_RegWrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            MemReadOut,
  output logic            MemtoRegOut,
  output logic            MemWriteOut,
  output logic            RegWriteOut,
  output logic [XLEN-1:0] ALUResultOut,
  output logic [XLEN-1:0] StoreDataOut,
  output logic [4:0]      rdOut,
  output logic            pc_src,
  output logic [XLEN-1:0] branch_target
);

  logic [XLEN-1:0] w_fwd_a;
  logic [XLEN-1:0] w_fwd_b;
  logic [XLEN-1:0] w_op2;
  logic [XLEN-1:0] w_alu_result;
  logic [XLEN-1:0] w_target;
  logic [3:0]      w_alu_funct;
  logic [5:0]      w_shamt;
  logic            w_lt_signed;
  logic            w_lt_unsigned;
  logic            w_br_cond;
  logic            w_taken;

  // NOTE: every always_comb output gets a default first so no path can infer a latch;
  // the later assignment wins, which also encodes EX/MEM-over-MEM/WB priority.
  always_comb begin
    w_fwd_a = ReadData1;
    if (wb_RegWrite && (wb_rd != 5'd0) && (wb_rd == rs1)) w_fwd_a = wb_data;
    if (RegWriteOut && (rdOut != 5'd0) && (rdOut == rs1)) w_fwd_a = ALUResultOut;
    w_fwd_b = ReadData2;
    if (wb_RegWrite && (wb_rd != 5'd0) && (wb_rd == rs2)) w_fwd_b = wb_data;
    if (RegWriteOut && (rdOut != 5'd0) && (rdOut == rs2)) w_fwd_b = ALUResultOut;
  end

  assign w_op2         = ALUSrc ? imm_data : w_fwd_b;
  assign w_shamt       = w_op2[5:0];
  assign w_lt_signed   = $signed(w_fwd_a) < $signed(w_op2);
  assign w_lt_unsigned = w_fwd_a < w_op2;
  assign w_target      = address + imm_data;

  // I-type reuses the R-type decode; instr[30] only selects srai over srli there.
  always_comb begin
    w_alu_funct = 4'b0000;
    case (AluOp)
      2'b00:   w_alu_funct = 4'b0000;
      2'b01:   w_alu_funct = 4'b1000;
      2'b10:   w_alu_funct = funct;
      default: w_alu_funct = (funct[2:0] == 3'b101) ? funct : {1'b0, funct[2:0]};
    endcase
  end

  always_comb begin
    w_alu_result = '0;
    case (w_alu_funct)
      4'b0000: w_alu_result = w_fwd_a + w_op2;
      4'b1000: w_alu_result = w_fwd_a - w_op2;
      4'b0111: w_alu_result = w_fwd_a & w_op2;
      4'b0110: w_alu_result = w_fwd_a | w_op2;
      4'b0100: w_alu_result = w_fwd_a ^ w_op2;
      4'b0001: w_alu_result = w_fwd_a << w_shamt;
      4'b0101: w_alu_result = w_fwd_a >> w_shamt;
      4'b1101: w_alu_result = $unsigned($signed(w_fwd_a) >>> w_shamt);
      4'b0010: w_alu_result = {{(XLEN-1){1'b0}}, w_lt_signed};
      4'b0011: w_alu_result = {{(XLEN-1){1'b0}}, w_lt_unsigned};
      default: w_alu_result = '0;
    endcase
  end

  // Branch compares the two register operands, never the immediate.
  always_comb begin
    w_br_cond = 1'b0;
    case (funct[2:0])
      3'b000:  w_br_cond = (w_fwd_a == w_fwd_b);
      3'b001:  w_br_cond = (w_fwd_a != w_fwd_b);
      3'b100:  w_br_cond = $signed(w_fwd_a) <  $signed(w_fwd_b);
      3'b101:  w_br_cond = $signed(w_fwd_a) >= $signed(w_fwd_b);
      default: w_br_cond = 1'b0;
    endcase
  end

  assign w_taken = branch && w_br_cond;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      MemReadOut    <= 1'b0;
      MemtoRegOut   <= 1'b0;
      MemWriteOut   <= 1'b0;
      RegWriteOut   <= 1'b0;
      ALUResultOut  <= '0;
      StoreDataOut  <= '0;
      rdOut         <= '0;
      pc_src        <= 1'b0;
      branch_target <= '0;
    end else begin
      ALUResultOut  <= w_alu_result;
      StoreDataOut  <= w_fwd_b;
      rdOut         <= rd;
      branch_target <= w_target;
      if (pc_src) begin
        // Instruction in EX is on the wrong path: capture a bubble.
        MemReadOut  <= 1'b0;
        MemtoRegOut <= 1'b0;
        MemWriteOut <= 1'b0;
        RegWriteOut <= 1'b0;
        pc_src      <= 1'b0;
      end else begin
        MemReadOut  <= MemRead;
        MemtoRegOut <= MemtoReg;
        MemWriteOut <= MemWrite;
        RegWriteOut <= RegWrite;
        pc_src      <= w_taken;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed plan steps then randomized instructions,
// compared against a mnemonic-level reference model of the EX/MEM register.
module tb_ex_mem_stage;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic            MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, branch;
  logic [XLEN-1:0] ReadData1, ReadData2, imm_data, address;
  logic [3:0]      funct;
  logic [4:0]      rd, rs1, rs2;
  logic [1:0]      AluOp;
  logic            wb_RegWrite;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            MemReadOut, MemtoRegOut, MemWriteOut, RegWriteOut, pc_src;
  logic [XLEN-1:0] ALUResultOut, StoreDataOut, branch_target;
  logic [4:0]      rdOut;

  ex_mem_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .MemRead(MemRead), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUSrc(ALUSrc),
    .RegWrite(RegWrite), .branch(branch),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .imm_data(imm_data), .address(address),
    .funct(funct), .rd(rd), .rs1(rs1), .rs2(rs2), .AluOp(AluOp),
    .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .MemReadOut(MemReadOut), .MemtoRegOut(MemtoRegOut), .MemWriteOut(MemWriteOut),
    .RegWriteOut(RegWriteOut), .ALUResultOut(ALUResultOut), .StoreDataOut(StoreDataOut),
    .rdOut(rdOut), .pc_src(pc_src), .branch_target(branch_target)
  );

  typedef struct packed {
    logic            memread, memtoreg, memwrite, regwrite, pc_src;
    logic [XLEN-1:0] alu, store, target;
    logic [4:0]      rd;
  } exm_t;

  typedef enum {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
                OP_SLT, OP_SLTU, OP_ZERO} op_e;

  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;
  exm_t m = '0;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic op_e decode_op();
    if (AluOp == 2'b00) return OP_ADD;
    if (AluOp == 2'b01) return OP_SUB;
    if (AluOp == 2'b11) begin
      case (funct[2:0])
        3'b000: return OP_ADD;
        3'b111: return OP_AND;
        3'b110: return OP_OR;
        3'b100: return OP_XOR;
        3'b001: return OP_SLL;
        3'b101: return funct[3] ? OP_SRA : OP_SRL;
        3'b010: return OP_SLT;
        default: return OP_SLTU;
      endcase
    end
    case (funct)
      4'b0000: return OP_ADD;
      4'b1000: return OP_SUB;
      4'b0111: return OP_AND;
      4'b0110: return OP_OR;
      4'b0100: return OP_XOR;
      4'b0001: return OP_SLL;
      4'b0101: return OP_SRL;
      4'b1101: return OP_SRA;
      4'b0010: return OP_SLT;
      4'b0011: return OP_SLTU;
      default: return OP_ZERO;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] forward(input logic [4:0] rs, input logic [XLEN-1:0] rf,
                                               input exm_t cur);
    if (cur.regwrite && cur.rd != 0 && cur.rd == rs) return cur.alu;
    if (wb_RegWrite && wb_rd != 0 && wb_rd == rs) return wb_data;
    return rf;
  endfunction

  function automatic exm_t model_next(input exm_t cur);
    exm_t            n;
    logic [XLEN-1:0] a, b, y, r;
    int              sh;
    logic            cond;
    n = '0;
    if (reset) return n;
    a  = forward(rs1, ReadData1, cur);
    b  = forward(rs2, ReadData2, cur);
    y  = ALUSrc ? imm_data : b;
    sh = int'(y % 64);
    case (decode_op())
      OP_ADD:  r = a + y;
      OP_SUB:  r = a - y;
      OP_AND:  r = a & y;
      OP_OR:   r = a | y;
      OP_XOR:  r = a ^ y;
      OP_SLL:  r = a << sh;
      OP_SRL:  r = a >> sh;
      OP_SRA:  r = $unsigned($signed(a) >>> sh);
      OP_SLT:  r = ($signed(a) < $signed(y)) ? 64'd1 : 64'd0;
      OP_SLTU: r = (a < y) ? 64'd1 : 64'd0;
      default: r = '0;
    endcase
    case (funct[2:0])
      3'b000:  cond = (a == b);
      3'b001:  cond = (a != b);
      3'b100:  cond = $signed(a) < $signed(b);
      3'b101:  cond = !($signed(a) < $signed(b));
      default: cond = 1'b0;
    endcase
    n.alu    = r;
    n.store  = b;
    n.rd     = rd;
    n.target = address + imm_data;
    if (!cur.pc_src) begin
      n.memread  = MemRead;
      n.memtoreg = MemtoReg;
      n.memwrite = MemWrite;
      n.regwrite = RegWrite;
      n.pc_src   = branch && cond;
    end
    return n;
  endfunction

  task automatic step(input string tag);
    exm_t nxt;
    logic squash;
    squash = m.pc_src && !reset;
    nxt    = model_next(m);
    @(posedge clk);
    #1;
    m = nxt;
    check({tag, ".memread"},  64'(MemReadOut),  64'(m.memread));
    check({tag, ".memtoreg"}, 64'(MemtoRegOut), 64'(m.memtoreg));
    check({tag, ".memwrite"}, 64'(MemWriteOut), 64'(m.memwrite));
    check({tag, ".regwrite"}, 64'(RegWriteOut), 64'(m.regwrite));
    check({tag, ".pc_src"},   64'(pc_src),      64'(m.pc_src));
    if (!squash) begin
      check({tag, ".alu"},    ALUResultOut,  m.alu);
      check({tag, ".store"},  StoreDataOut,  m.store);
      check({tag, ".rd"},     64'(rdOut),    64'(m.rd));
      check({tag, ".target"}, branch_target, m.target);
    end
  endtask

  task automatic set_nop();
    {MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, branch} = '0;
    ReadData1 = '0; ReadData2 = '0; imm_data = '0; address = '0;
    funct = '0; rd = '0; rs1 = '0; rs2 = '0; AluOp = '0;
    wb_RegWrite = 1'b0; wb_rd = '0; wb_data = '0;
  endtask

  function automatic logic [XLEN-1:0] rnd_data();
    case ($urandom_range(0, 3))
      0:       return {$urandom, $urandom};
      1:       return 64'($urandom_range(0, 15));
      2:       return 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
      default: return 64'h8000_0000_0000_0000;
    endcase
  endfunction

  task automatic randomize_inputs();
    MemRead  = 1'($urandom); MemtoReg = 1'($urandom); MemWrite = 1'($urandom);
    ALUSrc   = 1'($urandom); RegWrite = 1'($urandom);
    branch   = ($urandom_range(0, 3) == 0);
    ReadData1 = rnd_data(); ReadData2 = rnd_data(); imm_data = rnd_data(); address = rnd_data();
    funct = 4'($urandom); AluOp = 2'($urandom);
    rd  = 5'($urandom_range(0, 3)); rs1 = 5'($urandom_range(0, 3)); rs2 = 5'($urandom_range(0, 3));
    wb_RegWrite = 1'($urandom); wb_rd = 5'($urandom_range(0, 3)); wb_data = rnd_data();
  endtask

  task automatic set_branch(input logic [2:0] f3);
    set_nop();
    branch = 1'b1; AluOp = 2'b01; funct = {1'b0, f3};
    rs1 = 5'd9; rs2 = 5'd10;
    ReadData1 = 64'hFFFF_FFFF_FFFF_FFFF; ReadData2 = 64'd1;
  endtask

  task automatic set_rtype(input logic [3:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    set_nop();
    AluOp = 2'b10; funct = f; RegWrite = 1'b1; rd = 5'd12;
    rs1 = 5'd13; rs2 = 5'd14; ReadData1 = a; ReadData2 = b;
  endtask

  initial begin
    set_nop();

    // Reset with random inputs
    reset = 1'b1;
    randomize_inputs(); step("rst0");
    randomize_inputs(); step("rst1");
    check("rst_alu", ALUResultOut, 64'd0);
    reset = 1'b0;

    set_rtype(4'b0000, 64'd5, 64'd7); rd = 5'd3;
    step("add_x3");
    check("add_x3_val", ALUResultOut, 64'd12);
    check("add_x3_rd",  64'(rdOut), 64'd3);

    // Forwarding priority: EX/MEM beats MEM/WB
    set_rtype(4'b0000, 64'd4, 64'd6); rd = 5'd1; rs1 = 5'd20; rs2 = 5'd21;
    step("add_x1");
    set_rtype(4'b1000, 64'd99, 64'd3); rd = 5'd2; rs1 = 5'd1; rs2 = 5'd22;
    wb_RegWrite = 1'b1; wb_rd = 5'd1; wb_data = 64'd50;
    step("sub_fwd");
    check("fwd_exmem_wins", ALUResultOut, 64'd7);

    // x0 never forwards from either source
    set_rtype(4'b0000, 64'd4, 64'd6); rd = 5'd0; rs1 = 5'd20; rs2 = 5'd21;
    step("add_x0");
    set_rtype(4'b1000, 64'd99, 64'd3); rd = 5'd2; rs1 = 5'd0; rs2 = 5'd22;
    wb_RegWrite = 1'b1; wb_rd = 5'd0; wb_data = 64'd50;
    step("sub_x0");
    check("fwd_x0_none", ALUResultOut, 64'd96);

    // Store data forwarded from MEM/WB
    set_nop();
    AluOp = 2'b00; ALUSrc = 1'b1; MemWrite = 1'b1; imm_data = 64'd8;
    rs1 = 5'd6; ReadData1 = 64'h100; rs2 = 5'd5; ReadData2 = 64'd0;
    wb_RegWrite = 1'b1; wb_rd = 5'd5; wb_data = 64'hDEAD;
    step("sd");
    check("sd_addr",  ALUResultOut, 64'h108);
    check("sd_data",  StoreDataOut, 64'hDEAD);
    check("sd_write", 64'(MemWriteOut), 64'd1);

    // Taken beq, then squash of the following addi
    set_nop();
    branch = 1'b1; AluOp = 2'b01; funct = 4'b0000;
    rs1 = 5'd7; rs2 = 5'd8; ReadData1 = 64'h77; ReadData2 = 64'h77;
    address = 64'h40; imm_data = 64'h10;
    step("beq");
    check("beq_taken",  64'(pc_src), 64'd1);
    check("beq_target", branch_target, 64'h50);
    set_nop();
    AluOp = 2'b11; funct = 4'b0000; ALUSrc = 1'b1; imm_data = 64'd1;
    RegWrite = 1'b1; MemWrite = 1'b1; rd = 5'd4; rs1 = 5'd15;
    step("addi_squash");
    check("squash_regwrite", 64'(RegWriteOut), 64'd0);
    check("squash_memwrite", 64'(MemWriteOut), 64'd0);
    check("redirect_one_cycle", 64'(pc_src), 64'd0);

    // Branch conditions on -1 vs 1
    set_branch(3'b001); step("bne");
    check("bne_taken", 64'(pc_src), 64'd1);
    set_nop(); step("nop_a");
    set_branch(3'b100); step("blt");
    check("blt_taken", 64'(pc_src), 64'd1);
    set_nop(); step("nop_b");
    set_branch(3'b101); step("bge");
    check("bge_not_taken", 64'(pc_src), 64'd0);
    set_branch(3'b010); step("f3_010");
    check("f3_010_not_taken", 64'(pc_src), 64'd0);

    // Reset while a taken branch is in EX drops the redirect
    set_branch(3'b001); reset = 1'b1;
    step("rst_branch");
    check("rst_drops_pc_src", 64'(pc_src), 64'd0);
    reset = 1'b0;

    // Shifts, compares, wrap
    set_rtype(4'b1101, 64'h8000_0000_0000_0000, 64'd63); step("sra");
    check("sra_val", ALUResultOut, 64'hFFFF_FFFF_FFFF_FFFF);
    set_rtype(4'b0101, 64'h8000_0000_0000_0000, 64'd63); step("srl");
    check("srl_val", ALUResultOut, 64'd1);
    set_rtype(4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1); step("sltu");
    check("sltu_val", ALUResultOut, 64'd0);
    set_rtype(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1); step("slt");
    check("slt_val", ALUResultOut, 64'd1);
    set_rtype(4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1); step("add_wrap");
    check("add_wrap_val", ALUResultOut, 64'd0);
    set_rtype(4'b1101, 64'h8000_0000_0000_0000, 64'd0);
    AluOp = 2'b11; ALUSrc = 1'b1; imm_data = 64'd63; step("srai");
    check("srai_val", ALUResultOut, 64'hFFFF_FFFF_FFFF_FFFF);

    // Randomized instruction stream with occasional reset
    for (int i = 0; i < 300; i++) begin
      randomize_inputs();
      reset = ($urandom_range(0, 49) == 0);
      step("rnd");
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
